bus_timer: RTL and testbench
============================

BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 32, meaning width of the LOAD and COUNT registers (1..32); unused upper read bits return 0.
REQ-002 SHALL have port clk, input, 1 bit, the single core clock.
REQ-003 SHALL have port n_rst, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port sel, input, 1 bit, the timer-region select decoded by memory_controller.
REQ-005 SHALL have port addr, input, 4 bits, byte offset; bits [3:2] select the register, bits [1:0] are ignored.
REQ-006 SHALL have port wrdata, input, 32 bits, bus write data.
REQ-007 SHALL have port wren, input, 1 bit, write strobe, qualified by sel.
REQ-008 SHALL have port rddata, output, 32 bits, combinational read data.
REQ-009 SHALL have port irq, output, 1 bit, level interrupt, equal to EXPIRED AND IRQ_EN.
REQ-010 SHALL have port timeout, output, 1 bit, registered one-cycle pulse on each expiry.

Function
REQ-011 SHALL map the register at offset 0x0 to CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits[15:8] PRESCALE, all other bits reading 0.
REQ-012 SHALL map the register at offset 0x4 to LOAD (read/write), 0x8 to COUNT (read/write), and 0xC to STATUS (bit0 EXPIRED, write 1 to clear).
REQ-013 SHALL update a register on the rising clk edge only when sel=1 and wren=1; rddata SHALL be 0 when sel=0.
REQ-014 SHALL implement an FSM with two states: IDLE (EN=0) and RUN (EN=1).
REQ-015 SHALL go from IDLE to RUN on a CTRL write with EN=1; in the same edge, COUNT<=LOAD and the prescaler clears to 0.
REQ-016 SHALL go from RUN to IDLE on a CTRL write with EN=0; COUNT SHALL then hold its value.
REQ-017 SHALL, in RUN, increment the prescaler each cycle and generate a tick when it equals PRESCALE, then wrap to 0; the tick period SHALL be PRESCALE+1 cycles.
REQ-018 SHALL, on a tick with COUNT!=0, decrement COUNT by 1.
REQ-019 SHALL, on a tick with COUNT==0, set EXPIRED, pulse timeout on the next cycle, and then either reload COUNT<=LOAD when AUTO_RELOAD=1, or clear EN and return to IDLE when AUTO_RELOAD=0.
REQ-020 SHALL give an expiry period of (LOAD+1)*(PRESCALE+1) cycles; LOAD=0 with AUTO_RELOAD=1 SHALL expire on every tick.
REQ-021 SHALL, on a LOAD write in RUN, leave COUNT unchanged; the new value SHALL take effect at the next reload.
REQ-022 SHALL, on a COUNT write in any state, override COUNT with wrdata[COUNT_WIDTH-1:0] and clear the prescaler; this write SHALL take priority over a same-cycle tick.
REQ-023 SHALL let a hardware EXPIRED set win over a same-cycle software W1C clear.
REQ-024 SHALL ignore writes to STATUS bits other than bit0, and SHALL make a write of 0 to bit0 a no-op.

Reset
REQ-025 SHALL, while n_rst=0, asynchronously force state=IDLE and CTRL, LOAD, COUNT, prescaler, EXPIRED and timeout to 0; irq SHALL be 0.
REQ-026 SHALL, when reset asserts mid-count, abandon the count and generate no timeout pulse.

Configuration
REQ-027 SHALL build the programmable prescaler only when macro BUS_TIMER_PRESCALER_EN is defined.
REQ-028 SHALL, without BUS_TIMER_PRESCALER_EN, tick on every RUN cycle, read CTRL[15:8] as 0, ignore writes to CTRL[15:8], and contain no prescaler logic.

Structure
REQ-029 SHALL place the register offset constants, the CTRL bit-position constants and the state enum typedef (TIMER_IDLE, TIMER_RUN) in fe_pkg.
REQ-030 SHALL implement the prescaler as sub-module bus_timer_prescaler, with inputs clk, n_rst, clear, enable and limit[7:0], and output tick.

Verification
REQ-031 SHALL test auto-reload: LOAD=4, PRESCALE=0, CTRL=0x3 -> timeout pulses every 5 cycles, and EXPIRED=1 after the first pulse.
REQ-032 SHALL test one-shot with prescaler: LOAD=2, PRESCALE=3, CTRL=0x1 -> exactly one timeout at 12 cycles, after which CTRL.EN reads 0 and COUNT reads 0.
REQ-033 SHALL test W1C collision: write STATUS=1 in the same cycle as an expiry -> EXPIRED stays 1; a write of 1 one cycle later -> EXPIRED reads 0.
REQ-034 SHALL test irq gating: with EXPIRED=1 and IRQ_EN=0, irq=0; then write CTRL=0x7 -> irq=1 the next cycle.
REQ-035 SHALL test reset mid-operation: pulse n_rst low while COUNT=3 -> every register reads 0 and no timeout occurs afterwards.
REQ-036 SHALL test the bus path: a write with sel=0, wren=1 leaves LOAD unchanged; a read at offset 0xC with sel=1 returns 0x0000000X (EXPIRED only).

Source files
------------

// File: rtl/fe_pkg.sv
// Shared definitions for bus_timer: register byte offsets, CTRL/STATUS bit
// positions and the two-state timer FSM encoding.
package fe_pkg;

  localparam logic [3:0] TIMER_OFF_CTRL   = 4'h0;
  localparam logic [3:0] TIMER_OFF_LOAD   = 4'h4;
  localparam logic [3:0] TIMER_OFF_COUNT  = 4'h8;
  localparam logic [3:0] TIMER_OFF_STATUS = 4'hC;

  localparam int unsigned CTRL_EN_BIT        = 0;
  localparam int unsigned CTRL_AUTO_BIT      = 1;
  localparam int unsigned CTRL_IRQEN_BIT     = 2;
  localparam int unsigned CTRL_PRESC_LSB     = 8;
  localparam int unsigned CTRL_PRESC_MSB     = 15;
  localparam int unsigned STATUS_EXPIRED_BIT = 0;

  typedef enum logic [0:0] {
    TIMER_IDLE = 1'b0,
    TIMER_RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/bus_timer_prescaler.sv
// Tick divider for bus_timer: one tick every limit+1 enabled cycles.
// Only built when BUS_TIMER_PRESCALER_EN is defined.
`ifdef BUS_TIMER_PRESCALER_EN
module bus_timer_prescaler (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       tick
);

  logic [7:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped down-counting timer (CTRL/LOAD/COUNT/STATUS).
// Define BUS_TIMER_PRESCALER_EN to build the programmable prescaler in CTRL[15:8].
module bus_timer
  import fe_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [31:0] wrdata,
  input  logic        wren,
  output logic [31:0] rddata,
  output logic        irq,
  output logic        timeout
);

  timer_state_e           state_q, state_d;
  logic                   auto_q, auto_d;
  logic                   irqen_q, irqen_d;
  logic                   expired_q, expired_d;
  logic                   timeout_q;
  logic [COUNT_WIDTH-1:0] load_q, load_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] wr_value;
  logic [3:0]             reg_off;
  logic                   wr, ctrl_wr, load_wr, count_wr, status_wr;
  logic                   run, start, stop, presc_clear;
  logic                   tick, tick_act, expire;
  logic                   unused_bus;

  assign reg_off     = {addr[3:2], 2'b00};
  assign wr          = sel & wren;
  assign ctrl_wr     = wr && (reg_off == TIMER_OFF_CTRL);
  assign load_wr     = wr && (reg_off == TIMER_OFF_LOAD);
  assign count_wr    = wr && (reg_off == TIMER_OFF_COUNT);
  assign status_wr   = wr && (reg_off == TIMER_OFF_STATUS);
  assign run         = (state_q == TIMER_RUN);
  assign start       = ctrl_wr && wrdata[CTRL_EN_BIT] && !run;
  assign stop        = ctrl_wr && !wrdata[CTRL_EN_BIT];
  assign presc_clear = start || count_wr;
  assign wr_value    = wrdata[COUNT_WIDTH-1:0];
  assign unused_bus  = ^{addr[1:0], wrdata};

`ifdef BUS_TIMER_PRESCALER_EN
  logic [7:0] prescale_q, prescale_d;

  bus_timer_prescaler u_prescaler (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (presc_clear),
    .enable(run),
    .limit (prescale_q),
    .tick  (tick)
  );

  always_comb begin
    prescale_d = prescale_q;
    if (ctrl_wr) prescale_d = wrdata[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) prescale_q <= '0;
    else        prescale_q <= prescale_d;
  end
`else
  logic unused_presc_clear;
  assign unused_presc_clear = presc_clear;
  assign tick = run;
`endif

  // A COUNT write or a stopping CTRL write swallows a coincident tick entirely.
  assign tick_act = tick && !count_wr && !stop;
  assign expire   = tick_act && (count_q == '0);

  always_comb begin
    state_d   = state_q;
    auto_d    = auto_q;
    irqen_d   = irqen_q;
    load_d    = load_q;
    count_d   = count_q;
    expired_d = expired_q;

    if (tick_act) begin
      if (count_q != '0) count_d = count_q - COUNT_WIDTH'(1);
      else if (auto_q)   count_d = load_q;
      else               state_d = TIMER_IDLE;
    end

    if (ctrl_wr) begin
      auto_d  = wrdata[CTRL_AUTO_BIT];
      irqen_d = wrdata[CTRL_IRQEN_BIT];
      if (wrdata[CTRL_EN_BIT]) begin
        state_d = TIMER_RUN;
        if (!run) count_d = load_q;
      end else begin
        state_d = TIMER_IDLE;
      end
    end
    if (load_wr)  load_d  = wr_value;
    if (count_wr) count_d = wr_value;

    // Hardware set is applied last so it beats a same-cycle W1C.
    if (status_wr && wrdata[STATUS_EXPIRED_BIT]) expired_d = 1'b0;
    if (expire) expired_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= TIMER_IDLE;
      auto_q    <= 1'b0;
      irqen_q   <= 1'b0;
      load_q    <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      auto_q    <= auto_d;
      irqen_q   <= irqen_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      timeout_q <= expire;
    end
  end

  always_comb begin
    rddata = '0;
    if (sel) begin
      case (reg_off)
        TIMER_OFF_CTRL: begin
          rddata[CTRL_EN_BIT]    = run;
          rddata[CTRL_AUTO_BIT]  = auto_q;
          rddata[CTRL_IRQEN_BIT] = irqen_q;
`ifdef BUS_TIMER_PRESCALER_EN
          rddata[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = prescale_q;
`endif
        end
        TIMER_OFF_LOAD:   rddata = 32'(load_q);
        TIMER_OFF_COUNT:  rddata = 32'(count_q);
        TIMER_OFF_STATUS: rddata[STATUS_EXPIRED_BIT] = expired_q;
        default:          rddata = '0;
      endcase
    end
  end

  assign irq     = expired_q & irqen_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: deadline-based reference model plus
// directed register-level scenarios with literal expectations.
`timescale 1ns/1ps
module tb_bus_timer;

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_LOAD   = 4'h4;
  localparam logic [3:0] A_COUNT  = 4'h8;
  localparam logic [3:0] A_STATUS = 4'hC;
`ifdef BUS_TIMER_PRESCALER_EN
  localparam bit PRESC_EN = 1'b1;
`else
  localparam bit PRESC_EN = 1'b0;
`endif
  localparam int ONE_SHOT_CYC = PRESC_EN ? 12 : 3;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        sel = 1'b0;
  logic        wren = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wrdata = '0;
  logic [31:0] rddata;
  logic        irq, timeout;

  int total = 0;
  int bad = 0;

  bus_timer #(.COUNT_WIDTH(32)) dut (
    .clk(clk), .n_rst(n_rst), .sel(sel), .addr(addr), .wrdata(wrdata),
    .wren(wren), .rddata(rddata), .irq(irq), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: while running, remember the edge at which the next expiry happens.
  bit          m_run, m_auto, m_irqen, m_expired;
  logic [31:0] m_load, m_count;
  logic [7:0]  m_presc;
  longint      cyc = 0;
  longint      m_deadline = 0;
  longint      m_to_edge = -1;
  bit          e_wr, e_exp, e_was_run;
  logic [1:0]  e_r;

  function automatic longint period_of(input logic [7:0] p);
    return PRESC_EN ? (longint'(p) + 1) : longint'(1);
  endfunction

  function automatic logic [31:0] count_at(input longint c);
    longint pr, d;
    pr = period_of(m_presc);
    d  = m_deadline - c;
    return 32'((d + pr - 1) / pr - 1);
  endfunction

  function automatic logic [31:0] model_read(input logic s, input logic [3:0] a);
    logic [31:0] v;
    v = '0;
    if (s) begin
      case (a[3:2])
        2'd0: v = {16'h0, (PRESC_EN ? m_presc : 8'h00), 5'h0, m_irqen, m_auto, m_run};
        2'd1: v = m_load;
        2'd2: v = m_run ? count_at(cyc) : m_count;
        default: v = {31'h0, m_expired};
      endcase
    end
    return v;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_run = 0; m_auto = 0; m_irqen = 0; m_expired = 0;
      m_load = '0; m_count = '0; m_presc = '0;
      m_deadline = 0; m_to_edge = -1;
    end else begin
      cyc++;
      e_wr = sel && wren;
      e_r = addr[3:2];
      e_was_run = m_run;
      e_exp = m_run && (cyc == m_deadline) && !(e_wr && e_r == 2'd2)
              && !(e_wr && e_r == 2'd0 && !wrdata[0]);
      if (e_exp) begin
        m_expired = 1;
        m_to_edge = cyc;
        if (m_auto) m_deadline = cyc + (longint'(m_load) + 1) * period_of(m_presc);
        else begin m_run = 0; m_count = '0; end
      end
      if (e_wr) begin
        case (e_r)
          2'd0: begin
            if (!wrdata[0] && m_run) begin
              m_count = count_at(cyc - 1);
              m_run = 0;
            end
            m_auto = wrdata[1];
            m_irqen = wrdata[2];
            m_presc = wrdata[15:8];
            if (wrdata[0]) begin
              if (!e_was_run) begin
                m_run = 1;
                m_deadline = cyc + (longint'(m_load) + 1) * period_of(m_presc);
              end else if (!m_run) begin
                m_run = 1;
                m_deadline = cyc + period_of(m_presc);
              end
            end
          end
          2'd1: m_load = wrdata;
          2'd2: begin
            if (m_run) m_deadline = cyc + (longint'(wrdata) + 1) * period_of(m_presc);
            else m_count = wrdata;
          end
          default: if (wrdata[0] && !e_exp) m_expired = 0;
        endcase
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always begin
    @(negedge clk);
    #2;
    check("timeout", 32'(timeout), 32'(m_to_edge == cyc));
    check("irq", 32'(irq), 32'(m_expired & m_irqen));
    check("rddata", rddata, model_read(sel, addr));
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    sel = 1; wren = 1; addr = a; wrdata = d;
    @(negedge clk);
    sel = 0; wren = 0; wrdata = '0;
  endtask

  task automatic bus_write_rd(input logic [3:0] a, input logic [31:0] d, output logic [31:0] rd);
    sel = 1; wren = 1; addr = a; wrdata = d;
    #1 rd = rddata;
    @(negedge clk);
    sel = 0; wren = 0; wrdata = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] rd);
    sel = 1; wren = 0; addr = a;
    #1 rd = rddata;
    @(negedge clk);
    sel = 0;
  endtask

  task automatic wait_timeout(input int max, output int n);
    n = 0;
    #1;
    while (timeout !== 1'b1 && n < max) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int n, cnt;

    repeat (3) @(negedge clk);
    n_rst = 1;
    @(negedge clk);
    bus_read(A_CTRL, rd);   check("reset_ctrl", rd, 32'h0);
    bus_read(A_LOAD, rd);   check("reset_load", rd, 32'h0);
    bus_read(A_COUNT, rd);  check("reset_count", rd, 32'h0);
    bus_read(A_STATUS, rd); check("reset_status", rd, 32'h0);

    // Auto-reload, LOAD=4: pulse every 5 cycles
    bus_write(A_LOAD, 32'd4);
    bus_write(A_CTRL, 32'h3);
    wait_timeout(50, n);
    check("autoreload_first", 32'(n), 32'd5);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      wait_timeout(50, n);
      check("autoreload_period", 32'(n + 1), 32'd5);
    end
    bus_read(A_STATUS, rd); check("autoreload_expired", rd, 32'h1);
    bus_write(A_CTRL, 32'h0);
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS, rd); check("status_cleared", rd, 32'h0);

    // One-shot with prescaler
    bus_write(A_LOAD, 32'd2);
    bus_write(A_CTRL, 32'h0000_0301);
    wait_timeout(60, n);
    check("oneshot_latency", 32'(n), 32'(ONE_SHOT_CYC));
    repeat (20) @(negedge clk);
    bus_read(A_CTRL, rd);  check("oneshot_en_cleared", rd & 32'h1, 32'h0);
    bus_read(A_COUNT, rd); check("oneshot_count", rd, 32'h0);

    // irq gating
    bus_read(A_STATUS, rd); check("gate_expired", rd, 32'h1);
    #1 check("irq_gated", 32'(irq), 32'h0);
    bus_write(A_CTRL, 32'h7);
    #1 check("irq_enabled", 32'(irq), 32'h1);
    bus_write(A_CTRL, 32'h4);
    bus_write(A_STATUS, 32'h1);
    #1 check("irq_cleared", 32'(irq), 32'h0);

    // W1C collision with expiry
    bus_write(A_LOAD, 32'd4);
    bus_write(A_CTRL, 32'h3);
    repeat (4) @(negedge clk);
    bus_write(A_STATUS, 32'h1);
    #1 check("w1c_collision_timeout", 32'(timeout), 32'h1);
    bus_write_rd(A_STATUS, 32'h1, rd);
    check("w1c_collision_kept", rd, 32'h1);
    bus_read(A_STATUS, rd); check("w1c_later_clears", rd, 32'h0);
    bus_write(A_CTRL, 32'h0);

    // Reset mid-count
    bus_write(A_LOAD, 32'd10);
    bus_write(A_CTRL, 32'h3);
    repeat (7) @(negedge clk);
    sel = 1; wren = 0; addr = A_COUNT;
    #1 check("count_before_reset", rddata, 32'd3);
    n_rst = 0;
    sel = 0;
    repeat (2) @(negedge clk);
    n_rst = 1;
    bus_read(A_CTRL, rd);   check("rst_ctrl", rd, 32'h0);
    bus_read(A_LOAD, rd);   check("rst_load", rd, 32'h0);
    bus_read(A_COUNT, rd);  check("rst_count", rd, 32'h0);
    bus_read(A_STATUS, rd); check("rst_status", rd, 32'h0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1 if (timeout === 1'b1) cnt++;
    end
    check("rst_no_timeout", 32'(cnt), 32'h0);

    // Bus path
    bus_write(A_LOAD, 32'h55);
    sel = 0; wren = 1; addr = A_LOAD; wrdata = 32'h1234;
    #1 check("unselected_rddata", rddata, 32'h0);
    @(negedge clk);
    wren = 0; wrdata = '0;
    bus_read(A_LOAD, rd);  check("unselected_write_ignored", rd, 32'h55);
    bus_read(4'h7, rd);    check("addr_low_bits_ignored", rd, 32'h55);

    // LOAD=0 with auto-reload expires on every tick
    bus_write(A_LOAD, 32'd0);
    bus_write(A_CTRL, 32'h3);
    wait_timeout(20, n);
    check("load0_first", 32'(n), 32'd1);
    @(negedge clk);
    wait_timeout(20, n);
    check("load0_period", 32'(n + 1), 32'd1);
    bus_read(A_STATUS, rd); check("status_expired_only", rd, 32'h0000_0001);
    bus_write(A_CTRL, 32'h0);
    bus_write(A_STATUS, 32'h1);

    // COUNT override while running, then reload from LOAD
    bus_write(A_LOAD, 32'd10);
    bus_write(A_CTRL, 32'h3);
    bus_write(A_COUNT, 32'd1);
    wait_timeout(50, n);
    check("count_override", 32'(n), 32'd2);
    @(negedge clk);
    wait_timeout(50, n);
    check("reload_after_override", 32'(n + 1), 32'd11);
    bus_write(A_CTRL, 32'h0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
